// File: rtl/gpu_blit_if.sv
// Shared byte-memory bus between the sprite blitter and the CPU-side memory.
// The master drives single-cycle strobes; read data arrives the cycle after mem_read.
interface gpu_blit_if;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [7:0]  mem_write_byte;
    logic [7:0]  mem_read_byte;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_write_byte,
        input  mem_read_byte
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_write_byte,
        output mem_read_byte
    );
endinterface

// File: rtl/gpu_blit.sv
// XOR sprite blitter (8/16 px rows, clip or wrap) and screen clear over a shared byte bus.
// Define GPU_BLIT_ROW_COLLISION_EN to count colliding rows on collision_rows.
module gpu_blit #(
    parameter logic [15:0] SCREEN_START = 16'h100,
    parameter int unsigned SCREEN_W     = 64,
    parameter int unsigned SCREEN_H     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              draw,
    input  logic              clear,
    input  logic [15:0]       addr,
    input  logic [3:0]        lines,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic              wide,
    input  logic              wrap,
    output logic              ready,
    output logic              collision,
    output logic [4:0]        collision_rows,
    gpu_blit_if.master        mem
);

    localparam logic [7:0]  ROW_BYTES_B   = 8'(SCREEN_W / 8);
    localparam logic [15:0] ROW_BYTES_W   = 16'(SCREEN_W / 8);
    localparam logic [13:0] CLEAR_BYTES_B = 14'(SCREEN_W * SCREEN_H / 8);
    localparam logic [7:0]  COL_MASK      = 8'(SCREEN_W / 8 - 1);
    localparam logic [8:0]  ROW_MASK      = 9'(SCREEN_H - 1);
    localparam logic [8:0]  SCREEN_H_B    = 9'(SCREEN_H);
    localparam logic [7:0]  X_MASK        = 8'(SCREEN_W - 1);
    localparam logic [7:0]  Y_MASK        = 8'(SCREEN_H - 1);

    typedef enum logic [2:0] {
        StIdle, StFetchHi, StFetchLo, StRmwRd, StRmwWr, StClear
    } state_e;

    state_e      state_q;
    logic [15:0] spr_addr_q;
    logic [7:0]  x0_q, y0_q;
    logic [4:0]  n_q, row_q;
    logic [1:0]  slot_q;
    logic        wide_q, wrap_q;
    logic [15:0] pat_q;
    logic [13:0] cnt_q;

    logic [23:0] shifted;
    logic [7:0]  pk;
    logic        hit;
    logic [7:0]  col0, nxt_col_full;
    logic [2:0]  nxt_slot_idx;
    logic        nxt_slot_ok;
    logic [4:0]  row_nxt;
    logic [8:0]  cur_r_full, cur_r;
    logic        nxt_row_ok;
    logic [15:0] slot0_addr, nxt_slot_addr, lo_fetch_addr, nxt_fetch_addr;

    function automatic logic [15:0] scr_addr(input logic [8:0] r, input logic [7:0] c);
        return SCREEN_START + {7'b0, r} * ROW_BYTES_W + {8'b0, c};
    endfunction

    always_comb begin
        shifted = {pat_q, 8'h00} >> x0_q[2:0];
        case (slot_q)
            2'd0:    pk = shifted[23:16];
            2'd1:    pk = shifted[15:8];
            default: pk = shifted[7:0];
        endcase
    end

    assign hit            = |(mem.mem_read_byte & pk);
    assign col0           = {3'b0, x0_q[7:3]};
    assign nxt_slot_idx   = {1'b0, slot_q} + 3'd1;
    assign nxt_col_full   = col0 + {5'b0, nxt_slot_idx};
    // Once one column slot falls off the right edge, every later slot does too.
    assign nxt_slot_ok    = (nxt_slot_idx < (wide_q ? 3'd3 : 3'd2)) &&
                            (wrap_q || nxt_col_full < ROW_BYTES_B);
    assign row_nxt        = row_q + 5'd1;
    assign cur_r_full     = {1'b0, y0_q} + {4'b0, row_q};
    assign cur_r          = cur_r_full & ROW_MASK;
    assign nxt_row_ok     = (row_nxt < n_q) && (wrap_q || (cur_r_full + 9'd1) < SCREEN_H_B);
    assign slot0_addr     = scr_addr(cur_r, col0 & COL_MASK);
    assign nxt_slot_addr  = scr_addr(cur_r, nxt_col_full & COL_MASK);
    assign lo_fetch_addr  = spr_addr_q + {10'b0, row_q, 1'b1};
    assign nxt_fetch_addr = spr_addr_q + (wide_q ? {10'b0, row_nxt, 1'b0} : {11'b0, row_nxt});

    assign ready              = (state_q == StIdle);
    // Screen byte S is on the bus during the write cycle, so the XOR is formed combinationally.
    assign mem.mem_write_byte = (state_q == StRmwWr) ? (mem.mem_read_byte ^ pk) : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            spr_addr_q    <= 16'h0;
            x0_q          <= 8'h0;
            y0_q          <= 8'h0;
            n_q           <= 5'd0;
            row_q         <= 5'd0;
            slot_q        <= 2'd0;
            wide_q        <= 1'b0;
            wrap_q        <= 1'b0;
            pat_q         <= 16'h0;
            cnt_q         <= 14'd0;
            collision     <= 1'b0;
            mem.mem_read  <= 1'b0;
            mem.mem_write <= 1'b0;
            mem.mem_addr  <= 16'h0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clear) begin
                        state_q <= StClear;
                        cnt_q   <= 14'd0;
                    end else if (draw) begin
                        collision  <= 1'b0;
                        spr_addr_q <= addr;
                        x0_q       <= x & X_MASK;
                        y0_q       <= y & Y_MASK;
                        wide_q     <= wide;
                        wrap_q     <= wrap;
                        row_q      <= 5'd0;
                        slot_q     <= 2'd0;
                        n_q        <= (lines == 4'd0 && wide) ? 5'd16 : {1'b0, lines};
                        if (lines != 4'd0 || wide) begin
                            state_q      <= StFetchHi;
                            mem.mem_read <= 1'b1;
                            mem.mem_addr <= addr;
                        end
                    end
                end
                StFetchHi: begin
                    slot_q       <= 2'd0;
                    mem.mem_read <= 1'b1;
                    if (wide_q) begin
                        state_q      <= StFetchLo;
                        mem.mem_addr <= lo_fetch_addr;
                    end else begin
                        state_q      <= StRmwRd;
                        mem.mem_addr <= slot0_addr;
                    end
                end
                StFetchLo: begin
                    pat_q[15:8]  <= mem.mem_read_byte;
                    state_q      <= StRmwRd;
                    mem.mem_read <= 1'b1;
                    mem.mem_addr <= slot0_addr;
                end
                StRmwRd: begin
                    // The last pattern byte lands during the first slot's screen read.
                    if (slot_q == 2'd0) begin
                        if (wide_q) pat_q[7:0] <= mem.mem_read_byte;
                        else        pat_q      <= {mem.mem_read_byte, 8'h00};
                    end
                    state_q       <= StRmwWr;
                    mem.mem_read  <= 1'b0;
                    mem.mem_write <= 1'b1;
                end
                StRmwWr: begin
                    collision     <= collision | hit;
                    mem.mem_write <= 1'b0;
                    if (nxt_slot_ok) begin
                        slot_q       <= nxt_slot_idx[1:0];
                        state_q      <= StRmwRd;
                        mem.mem_read <= 1'b1;
                        mem.mem_addr <= nxt_slot_addr;
                    end else if (nxt_row_ok) begin
                        row_q        <= row_nxt;
                        state_q      <= StFetchHi;
                        mem.mem_read <= 1'b1;
                        mem.mem_addr <= nxt_fetch_addr;
                    end else begin
                        state_q      <= StIdle;
                        mem.mem_addr <= 16'h0;
                    end
                end
                StClear: begin
                    if (cnt_q == CLEAR_BYTES_B) begin
                        state_q       <= StIdle;
                        mem.mem_write <= 1'b0;
                        mem.mem_addr  <= 16'h0;
                    end else begin
                        mem.mem_write <= 1'b1;
                        mem.mem_addr  <= SCREEN_START + {2'b0, cnt_q};
                        cnt_q         <= cnt_q + 14'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef GPU_BLIT_ROW_COLLISION_EN
    logic [4:0] rows_q;
    logic       row_hit_q;
    logic       accept_draw, row_done;

    assign accept_draw = (state_q == StIdle) && draw && !clear;
    assign row_done    = (state_q == StRmwWr) && !nxt_slot_ok;

    always_ff @(posedge clk) begin
        if (reset || accept_draw) begin
            rows_q    <= 5'd0;
            row_hit_q <= 1'b0;
        end else if (state_q == StRmwWr) begin
            if (row_done) begin
                row_hit_q <= 1'b0;
                if ((row_hit_q | hit) && rows_q != 5'd16) rows_q <= rows_q + 5'd1;
            end else begin
                row_hit_q <= row_hit_q | hit;
            end
        end
    end

    assign collision_rows = rows_q;
`else
    assign collision_rows = 5'd0;
`endif

endmodule

// File: tb/tb_gpu_blit.sv
// Scoreboard bench for gpu_blit: expected bus accesses and completions are queued per command
// and checked by an independent monitor against a byte-memory model.
module tb_gpu_blit;

`ifdef GPU_BLIT_ROW_COLLISION_EN
    localparam bit ROW_EN = 1'b1;
`else
    localparam bit ROW_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        draw, clear, wide, wrap;
    logic [15:0] addr;
    logic [3:0]  lines;
    logic [7:0]  x, y;
    logic        ready, collision;
    logic [4:0]  collision_rows;

    always #5 clk = ~clk;

    gpu_blit_if bus ();

    gpu_blit #(
        .SCREEN_START (16'h100),
        .SCREEN_W     (64),
        .SCREEN_H     (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .draw           (draw),
        .clear          (clear),
        .addr           (addr),
        .lines          (lines),
        .x              (x),
        .y              (y),
        .wide           (wide),
        .wrap           (wrap),
        .ready          (ready),
        .collision      (collision),
        .collision_rows (collision_rows),
        .mem            (bus)
    );

    // Byte memory model with a bench-side poke port for setup.
    logic [7:0]  mem [0:65535];
    logic [7:0]  rd_q;
    logic        tb_we = 1'b0;
    logic [15:0] tb_wa = 16'h0;
    logic [7:0]  tb_wd = 8'h0;

    always @(posedge clk) begin
        if (tb_we) mem[tb_wa] <= tb_wd;
        else if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_write_byte;
        if (bus.mem_read) rd_q <= mem[bus.mem_addr];
    end
    assign bus.mem_read_byte = rd_q;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;
    typedef struct packed {
        logic       coll;
        logic [4:0] rows;
    } done_t;

    acc_t  acc_q[$];
    done_t done_q[$];
    int    tests = 0;
    int    fails = 0;

    function automatic logic [4:0] er(input int n);
        return ROW_EN ? 5'(n) : 5'd0;
    endfunction

    task automatic ex_rd(input logic [15:0] a);
        acc_q.push_back('{wr: 1'b0, addr: a, data: 8'h00});
    endtask

    task automatic ex_wr(input logic [15:0] a, input logic [7:0] d);
        acc_q.push_back('{wr: 1'b1, addr: a, data: d});
    endtask

    task automatic ex_done(input logic c, input logic [4:0] r);
        done_q.push_back('{coll: c, rows: r});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        tb_we = 1'b1;
        tb_wa = a;
        tb_wd = d;
        @(posedge clk);
        #1 tb_we = 1'b0;
    endtask

    task automatic run_cmd(input logic d, input logic c, input logic [15:0] a,
                           input logic [3:0] l, input logic [7:0] xx, input logic [7:0] yy,
                           input logic w, input logic wr, output int low);
        int guard;
        @(negedge clk);
        guard = 0;
        while (ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        draw = d; clear = c; addr = a; lines = l; x = xx; y = yy; wide = w; wrap = wr;
        @(posedge clk);
        #1;
        draw  = 1'b0;
        clear = 1'b0;
        low   = 0;
        @(negedge clk);
        while (ready !== 1'b1 && low < 5000) begin
            low++;
            @(negedge clk);
        end
        if (low >= 5000) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout: got ready=%0b, expected 1", ready);
        end
    endtask

    task automatic check_screen_zero(input string name);
        int nz;
        nz = 0;
        for (int i = 0; i < 256; i++) if (mem[16'h100 + 16'(i)] !== 8'h00) nz++;
        check(name, 32'(nz), 32'd0);
    endtask

    // Monitor: every bus strobe pops one expected access; each ready rise pops one completion.
    initial begin : monitor
        acc_t  e;
        done_t dn;
        logic  ready_prev;
        ready_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.mem_read === 1'b1 || bus.mem_write === 1'b1) begin
                tests++;
                if (bus.mem_read && bus.mem_write) begin
                    fails++;
                    $display("FAIL bus_both: got rd=1 wr=1 at %0h, expected one strobe",
                             bus.mem_addr);
                end else if (acc_q.size() == 0) begin
                    fails++;
                    $display("FAIL bus_extra: got wr=%0b addr=%0h, expected no access",
                             bus.mem_write, bus.mem_addr);
                end else begin
                    e = acc_q.pop_front();
                    if (e.wr !== bus.mem_write || e.addr !== bus.mem_addr ||
                        (e.wr && e.data !== bus.mem_write_byte)) begin
                        fails++;
                        $display("FAIL bus_access: got wr=%0b addr=%0h data=%0h, expected wr=%0b addr=%0h data=%0h",
                                 bus.mem_write, bus.mem_addr, bus.mem_write_byte,
                                 e.wr, e.addr, e.data);
                    end
                end
            end
            if (ready === 1'b1 && ready_prev !== 1'b1 && done_q.size() > 0) begin
                dn = done_q.pop_front();
                tests++;
                if (collision !== dn.coll || collision_rows !== dn.rows) begin
                    fails++;
                    $display("FAIL done: got collision=%0b rows=%0d, expected collision=%0b rows=%0d",
                             collision, collision_rows, dn.coll, dn.rows);
                end
            end
            ready_prev = ready;
        end
    end

    initial begin : stim
        int low;
        reset = 1'b1;
        draw = 1'b0; clear = 1'b0; addr = 16'h0; lines = 4'd0;
        x = 8'h0; y = 8'h0; wide = 1'b0; wrap = 1'b0;
        for (int i = 0; i < 256; i++) poke(16'h100 + 16'(i), 8'h00);
        poke(16'h200, 8'hF0);
        poke(16'h201, 8'hFF);
        poke(16'h210, 8'hFF);
        poke(16'h211, 8'hFF);
        for (int i = 0; i < 32; i++) poke(16'h300 + 16'(i), 8'hFF);
        for (int i = 0; i < 3; i++) poke(16'h400 + 16'(i), 8'h80);

        check("rst_ready", 32'(ready), 32'd1);
        check("rst_collision", 32'(collision), 32'd0);
        check("rst_rows", 32'(collision_rows), 32'd0);
        check("rst_mem_read", 32'(bus.mem_read), 32'd0);
        check("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wbyte", 32'(bus.mem_write_byte), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Narrow F0 at origin, then redraw to erase with collision.
        ex_rd(16'h200); ex_rd(16'h100); ex_wr(16'h100, 8'hF0); ex_rd(16'h101); ex_wr(16'h101, 8'h00);
        ex_done(1'b0, 5'd0);
        run_cmd(1'b1, 1'b0, 16'h200, 4'd1, 8'd0, 8'd0, 1'b0, 1'b0, low);
        ex_rd(16'h200); ex_rd(16'h100); ex_wr(16'h100, 8'h00); ex_rd(16'h101); ex_wr(16'h101, 8'h00);
        ex_done(1'b1, er(1));
        run_cmd(1'b1, 1'b0, 16'h200, 4'd1, 8'd0, 8'd0, 1'b0, 1'b0, low);

        // Unaligned narrow draw at x=4, y=1.
        ex_rd(16'h201); ex_rd(16'h108); ex_wr(16'h108, 8'h0F); ex_rd(16'h109); ex_wr(16'h109, 8'hF0);
        ex_done(1'b0, 5'd0);
        run_cmd(1'b1, 1'b0, 16'h201, 4'd1, 8'd4, 8'd1, 1'b0, 1'b0, low);

        // Bottom-right corner, clipped.
        ex_rd(16'h210); ex_rd(16'h1FF); ex_wr(16'h1FF, 8'h0F);
        ex_done(1'b0, 5'd0);
        run_cmd(1'b1, 1'b0, 16'h210, 4'd2, 8'd60, 8'd31, 1'b0, 1'b0, low);

        // Full clear: 256 zero writes, collision kept.
        for (int i = 0; i < 256; i++) ex_wr(16'h100 + 16'(i), 8'h00);
        ex_done(1'b0, 5'd0);
        run_cmd(1'b0, 1'b1, 16'h0, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, low);
        check("clear_busy_cycles", 32'(low), 32'd257);
        check_screen_zero("clear_screen_zero");

        // Bottom-right corner, wrapped on both axes.
        ex_rd(16'h210); ex_rd(16'h1FF); ex_wr(16'h1FF, 8'h0F); ex_rd(16'h1F8); ex_wr(16'h1F8, 8'hF0);
        ex_rd(16'h211); ex_rd(16'h107); ex_wr(16'h107, 8'h0F); ex_rd(16'h100); ex_wr(16'h100, 8'hF0);
        ex_done(1'b0, 5'd0);
        run_cmd(1'b1, 1'b0, 16'h210, 4'd2, 8'd60, 8'd31, 1'b0, 1'b1, low);

        // Wide 16x16 at x=3; row 0 overlaps the F0 left at 0x100.
        for (int i = 0; i < 16; i++) begin
            ex_rd(16'h300 + 16'(2 * i));
            ex_rd(16'h301 + 16'(2 * i));
            ex_rd(16'h100 + 16'(8 * i));
            ex_wr(16'h100 + 16'(8 * i), (i == 0) ? 8'hEF : 8'h1F);
            ex_rd(16'h101 + 16'(8 * i));
            ex_wr(16'h101 + 16'(8 * i), 8'hFF);
            ex_rd(16'h102 + 16'(8 * i));
            ex_wr(16'h102 + 16'(8 * i), 8'hE0);
        end
        ex_done(1'b1, er(1));
        run_cmd(1'b1, 1'b0, 16'h300, 4'd0, 8'd3, 8'd0, 1'b1, 1'b0, low);

        // Three-row sprite drawn twice: every row collides on the second pass.
        for (int i = 0; i < 3; i++) begin
            ex_rd(16'h400 + 16'(i));
            ex_rd(16'h180 + 16'(8 * i)); ex_wr(16'h180 + 16'(8 * i), 8'h80);
            ex_rd(16'h181 + 16'(8 * i)); ex_wr(16'h181 + 16'(8 * i), 8'h00);
        end
        ex_done(1'b0, 5'd0);
        run_cmd(1'b1, 1'b0, 16'h400, 4'd3, 8'd0, 8'd16, 1'b0, 1'b0, low);
        for (int i = 0; i < 3; i++) begin
            ex_rd(16'h400 + 16'(i));
            ex_rd(16'h180 + 16'(8 * i)); ex_wr(16'h180 + 16'(8 * i), 8'h00);
            ex_rd(16'h181 + 16'(8 * i)); ex_wr(16'h181 + 16'(8 * i), 8'h00);
        end
        ex_done(1'b1, er(3));
        run_cmd(1'b1, 1'b0, 16'h400, 4'd3, 8'd0, 8'd16, 1'b0, 1'b0, low);

        // clear with draw wins; a draw pulse mid-clear must be ignored.
        for (int i = 0; i < 256; i++) ex_wr(16'h100 + 16'(i), 8'h00);
        ex_done(1'b1, er(3));
        fork
            run_cmd(1'b1, 1'b1, 16'h200, 4'd1, 8'd0, 8'd0, 1'b0, 1'b0, low);
            begin
                repeat (10) @(negedge clk);
                draw = 1'b1;
                @(negedge clk);
                draw = 1'b0;
            end
        join
        check("clear_draw_busy_cycles", 32'(low), 32'd257);
        check_screen_zero("clear_draw_screen_zero");

        // lines=0 narrow: no bus traffic, collision cleared.
        run_cmd(1'b1, 1'b0, 16'h200, 4'd0, 8'd0, 8'd0, 1'b0, 1'b0, low);
        repeat (3) @(negedge clk);
        check("noop_collision", 32'(collision), 32'd0);
        check("noop_ready", 32'(ready), 32'd1);

        // Reset during the first screen read of a draw.
        ex_rd(16'h200); ex_rd(16'h100);
        @(negedge clk);
        draw = 1'b1; addr = 16'h200; lines = 4'd1; x = 8'd0; y = 8'd0; wide = 1'b0; wrap = 1'b0;
        @(posedge clk);
        #1 draw = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_mem_read", 32'(bus.mem_read), 32'd0);
        check("midrst_mem_write", 32'(bus.mem_write), 32'd0);
        check("midrst_rows", 32'(collision_rows), 32'd0);
        reset = 1'b0;

        repeat (5) @(negedge clk);
        check("acc_queue_empty", 32'(acc_q.size()), 32'd0);
        check("done_queue_empty", 32'(done_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
